// File: rtl/gift_pkg.sv
// Shared GIFT-128 constants, permutation index, and engine FSM encoding.
package gift_pkg;

   localparam int unsigned STATE_W = 128;
   localparam int unsigned KEY_W   = 128;
   localparam int unsigned LFSR_W  = 6;
   localparam int unsigned NIB_N   = STATE_W / 4;

   // 4-bit GIFT S-box, indexed by input nibble value
   localparam logic [3:0] GIFT_SBOX [16] = '{
      4'h1, 4'ha, 4'h4, 4'hc, 4'h6, 4'hf, 4'h3, 4'h9,
      4'h2, 4'hd, 4'hb, 4'h7, 4'h5, 4'h0, 4'h8, 4'he
   };

   // State bit receiving round-constant bit c[j]
   localparam int unsigned RC_BIT [LFSR_W] = '{3, 7, 11, 15, 19, 23};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Destination position of state bit i under the 128-bit bit permutation
   function automatic int unsigned perm128(input int unsigned i);
      return 4 * (i / 16) + 32 * ((3 * ((i % 16) / 4) + (i % 4)) % 4) + (i % 4);
   endfunction

endpackage

// File: rtl/gift128_round_comb.sv
// One GIFT-128 round plus key-schedule and round-constant update, purely combinational.
module gift128_round_comb
   import gift_pkg::*;
(
   input  logic [STATE_W-1:0] i_s,
   input  logic [KEY_W-1:0]   i_key,
   input  logic [LFSR_W-1:0]  i_lfsr,
   output logic [STATE_W-1:0] o_s,
   output logic [KEY_W-1:0]   o_key,
   output logic [LFSR_W-1:0]  o_lfsr
);

   logic [STATE_W-1:0] w_sub;
   logic [STATE_W-1:0] w_perm;
   logic [STATE_W-1:0] w_ark;
   logic [LFSR_W-1:0]  w_lfsr_nxt;
   logic [31:0]        w_u;
   logic [31:0]        w_v;

   // SubCells, PermBits, AddRoundKey and constant injection with the advanced LFSR
   always_comb begin
      w_sub      = '0;
      w_perm     = '0;
      w_lfsr_nxt = {i_lfsr[4:0], i_lfsr[5] ^ i_lfsr[4] ^ 1'b1};
      w_u        = i_key[95:64];
      w_v        = i_key[31:0];
      for (int i = 0; i < int'(NIB_N); i++) begin
         w_sub[4*i +: 4] = GIFT_SBOX[i_s[4*i +: 4]];
      end
      for (int i = 0; i < int'(STATE_W); i++) begin
         w_perm[7'(perm128(32'(i)))] = w_sub[i];
      end
      w_ark = w_perm;
      for (int i = 0; i < int'(NIB_N); i++) begin
         w_ark[4*i+2] = w_ark[4*i+2] ^ w_u[i];
         w_ark[4*i+1] = w_ark[4*i+1] ^ w_v[i];
      end
      for (int j = 0; j < int'(LFSR_W); j++) begin
         w_ark[7'(RC_BIT[j])] = w_ark[7'(RC_BIT[j])] ^ w_lfsr_nxt[j];
      end
      w_ark[STATE_W-1] = ~w_ark[STATE_W-1];
   end

   assign o_s    = w_ark;
   assign o_lfsr = w_lfsr_nxt;
   // Key words rotate down by two; k1>>>2 and k0>>>12 refill the top
   assign o_key  = {i_key[17:16], i_key[31:18], i_key[11:0], i_key[15:12], i_key[127:32]};

endmodule

// File: rtl/gift128_round_engine.sv
// Iterative GIFT-128 encryption engine, one round per clock, start/done/ack handshake.
module gift128_round_engine
   import gift_pkg::*;
#(
   parameter int unsigned NUM_ROUNDS = 40
) (
   input  logic               inClk,
   input  logic               inRst,
   input  logic               inStart,
   input  logic [STATE_W-1:0] inData,
   input  logic [KEY_W-1:0]   inKey,
   input  logic               inAck,
   output logic               outBusy,
   output logic               outValid,
   output logic [STATE_W-1:0] outData
);

   localparam int unsigned CNT_W = $clog2(NUM_ROUNDS + 1);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [STATE_W-1:0] r_s;
   logic [KEY_W-1:0]   r_key;
   logic [LFSR_W-1:0]  r_lfsr;
   logic [CNT_W-1:0]   r_cnt;
   logic [STATE_W-1:0] w_s_nxt;
   logic [KEY_W-1:0]   w_key_nxt;
   logic [LFSR_W-1:0]  w_lfsr_nxt;
   logic               w_load;
   logic               w_step;
   logic               w_finish;
   logic               w_busy_nxt;
   logic               w_valid_nxt;

   gift128_round_comb u_round (
      .i_s    (r_s),
      .i_key  (r_key),
      .i_lfsr (r_lfsr),
      .o_s    (w_s_nxt),
      .o_key  (w_key_nxt),
      .o_lfsr (w_lfsr_nxt)
   );

   // FSM state register
   always_ff @(posedge inClk) begin
      if (inRst) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next state, datapath strobes and next handshake outputs
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_step      = 1'b0;
      w_finish    = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (inStart) begin
               w_state_nxt = ST_RUN;
               w_load      = 1'b1;
            end
         end
         ST_RUN: begin
            w_step = 1'b1;
            if (r_cnt == CNT_W'(NUM_ROUNDS - 1)) begin
               w_state_nxt = ST_DONE;
               w_finish    = 1'b1;
            end
         end
         ST_DONE: begin
            if (inAck) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
      w_busy_nxt  = (w_state_nxt != ST_IDLE);
      w_valid_nxt = (w_state_nxt == ST_DONE);
   end

   // Round state, key, constant, counter and registered outputs
   always_ff @(posedge inClk) begin
      if (inRst) begin
         r_s      <= '0;
         r_key    <= '0;
         r_lfsr   <= '0;
         r_cnt    <= '0;
         outData  <= '0;
         outBusy  <= 1'b0;
         outValid <= 1'b0;
      end else begin
         outBusy  <= w_busy_nxt;
         outValid <= w_valid_nxt;
         if (w_load) begin
            r_s    <= inData;
            r_key  <= inKey;
            r_lfsr <= '0;
            r_cnt  <= '0;
         end else if (w_step) begin
            r_s    <= w_s_nxt;
            r_key  <= w_key_nxt;
            r_lfsr <= w_lfsr_nxt;
            r_cnt  <= r_cnt + CNT_W'(1);
         end
         if (w_finish) outData <= w_s_nxt;
      end
   end

endmodule

// File: tb/tb_gift128_round_engine.sv
// Self-checking bench: two engines (40 rounds and 1 round) against a software GIFT-128 model.
module tb_gift128_round_engine;

   localparam logic [127:0] CT_ZERO = 128'hcd0bd738388ad3f668b15a36ceb6ff92;
   localparam logic [127:0] V2      = 128'hfedcba9876543210fedcba9876543210;
   localparam logic [127:0] CT_V2   = 128'h8422241a6dbf5a9346af468409ee0152;
   localparam logic [127:0] CT_ONE0 = 128'h91111111111111111111111111111119;
   localparam int NR [2] = '{40, 1};
   localparam logic [3:0] SB [16] = '{
      4'h1, 4'ha, 4'h4, 4'hc, 4'h6, 4'hf, 4'h3, 4'h9,
      4'h2, 4'hd, 4'hb, 4'h7, 4'h5, 4'h0, 4'h8, 4'he
   };

   logic         clk;
   logic         rst   [2];
   logic         start [2];
   logic         ack   [2];
   logic [127:0] din   [2];
   logic [127:0] key   [2];
   logic         busy  [2];
   logic         valid [2];
   logic [127:0] dout  [2];

   int n_chk;
   int n_err;
   bit chk_en;

   // behavioural model state per engine
   bit           m_busy  [2];
   bit           m_valid [2];
   logic [127:0] m_data  [2];
   logic [127:0] m_pend  [2];
   int           m_left  [2];

   gift128_round_engine #(.NUM_ROUNDS(40)) u_dut40 (
      .inClk(clk), .inRst(rst[0]), .inStart(start[0]), .inData(din[0]), .inKey(key[0]),
      .inAck(ack[0]), .outBusy(busy[0]), .outValid(valid[0]), .outData(dout[0])
   );

   gift128_round_engine #(.NUM_ROUNDS(1)) u_dut1 (
      .inClk(clk), .inRst(rst[1]), .inStart(start[1]), .inData(din[1]), .inKey(key[1]),
      .inAck(ack[1]), .outBusy(busy[1]), .outValid(valid[1]), .outData(dout[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] rotr16(input logic [15:0] x, input int n);
      return (x >> n) | (x << (16 - n));
   endfunction

   // Straightforward software GIFT-128 over a given number of rounds
   function automatic logic [127:0] gift_enc(input logic [127:0] pt, input logic [127:0] k,
                                             input int rounds);
      logic [15:0]  kw [8];
      logic [15:0]  nk [8];
      logic [127:0] s;
      logic [127:0] t;
      int           c;
      for (int i = 0; i < 8; i++) kw[i] = k[16*i +: 16];
      s = pt;
      c = 0;
      for (int r = 0; r < rounds; r++) begin
         for (int n = 0; n < 32; n++) t[4*n +: 4] = SB[s[4*n +: 4]];
         s = '0;
         for (int i = 0; i < 128; i++)
            s[4*(i/16) + 32*((3*((i%16)/4) + (i%4)) % 4) + (i%4)] = t[i];
         c = ((c << 1) & 63) | (((c >> 5) ^ (c >> 4) ^ 1) & 1);
         for (int i = 0; i < 16; i++) begin
            s[4*i+2]      = s[4*i+2]      ^ kw[4][i];
            s[4*(i+16)+2] = s[4*(i+16)+2] ^ kw[5][i];
            s[4*i+1]      = s[4*i+1]      ^ kw[0][i];
            s[4*(i+16)+1] = s[4*(i+16)+1] ^ kw[1][i];
         end
         for (int j = 0; j < 6; j++) s[4*j+3] = s[4*j+3] ^ 1'((c >> j) & 1);
         s[127] = ~s[127];
         nk[7] = rotr16(kw[1], 2);
         nk[6] = rotr16(kw[0], 12);
         for (int i = 0; i < 6; i++) nk[i] = kw[i+2];
         kw = nk;
      end
      return s;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic chk_v(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic chk_b(input string nm, input int d, input logic act, input logic exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s dut%0d: got %b expected %b (t=%0t)", nm, NR[d], act, exp, $time);
      end
   endtask

   // Handshake-level model: a block becomes visible NR rounds after acceptance
   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (rst[d]) begin
            m_busy[d]  <= 1'b0;
            m_valid[d] <= 1'b0;
            m_data[d]  <= '0;
            m_left[d]  <= 0;
         end else if (!m_busy[d]) begin
            if (start[d]) begin
               m_busy[d] <= 1'b1;
               m_left[d] <= NR[d];
               m_pend[d] <= gift_enc(din[d], key[d], NR[d]);
            end
         end else if (!m_valid[d]) begin
            m_left[d] <= m_left[d] - 1;
            if (m_left[d] == 1) begin
               m_valid[d] <= 1'b1;
               m_data[d]  <= m_pend[d];
            end
         end else if (ack[d]) begin
            m_valid[d] <= 1'b0;
            m_busy[d]  <= 1'b0;
         end
      end
   end

   // Per-cycle comparison of both engines against the model
   always @(negedge clk) begin
      if (chk_en) begin
         for (int d = 0; d < 2; d++) begin
            chk_b("busy", d, busy[d], m_busy[d]);
            chk_b("valid", d, valid[d], m_valid[d]);
            chk_v(d == 0 ? "data_n40" : "data_n1", dout[d], m_data[d]);
         end
      end
   end

   task automatic wait_valid(input int d, output int lat);
      lat = 0;
      while (valid[d] !== 1'b1 && lat < NR[d] + 5) begin
         @(negedge clk);
         lat++;
      end
      chk_v("latency", 128'(lat), 128'(NR[d]));
   endtask

   // Start one block, optionally poke start/ack during RUN, hold result, then ack
   task automatic run_block(input int d, input logic [127:0] p, input logic [127:0] k,
                            input int hold, input bit disturb, output logic [127:0] ct);
      int lat;
      @(negedge clk);
      din[d] = p; key[d] = k; start[d] = 1'b1;
      @(negedge clk);
      start[d] = 1'b0; din[d] = rnd128(); key[d] = rnd128();
      lat = 0;
      while (valid[d] !== 1'b1 && lat < NR[d] + 5) begin
         if (disturb && lat == 5) begin start[d] = 1'b1; din[d] = rnd128(); end
         if (disturb && lat == 6) begin start[d] = 1'b0; ack[d] = 1'b1; end
         if (disturb && lat == 7) ack[d] = 1'b0;
         @(negedge clk);
         lat++;
      end
      chk_v("latency", 128'(lat), 128'(NR[d]));
      repeat (hold) @(negedge clk);
      ct = dout[d];
      ack[d] = 1'b1;
      @(negedge clk);
      ack[d] = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] ct, pa, ka, pb, kb;
      int lat;
      n_chk = 0; n_err = 0; chk_en = 1'b0;
      for (int d = 0; d < 2; d++) begin
         rst[d] = 1'b1; start[d] = 1'b0; ack[d] = 1'b0; din[d] = '0; key[d] = '0;
      end

      // pin the software model to known values
      chk_v("model_zero40", gift_enc('0, '0, 40), CT_ZERO);
      chk_v("model_v2_40", gift_enc(V2, V2, 40), CT_V2);
      chk_v("model_zero1", gift_enc('0, '0, 1), CT_ONE0);

      repeat (2) @(posedge clk);
      #1 chk_en = 1'b1;
      @(negedge clk);
      chk_v("reset_data", dout[0], '0);
      chk_b("reset_busy", 0, busy[0], 1'b0);
      rst[0] = 1'b0; rst[1] = 1'b0;

      run_block(0, '0, '0, 12, 1'b0, ct);
      chk_v("vec_zero", ct, CT_ZERO);
      run_block(0, V2, V2, 3, 1'b1, ct);
      chk_v("vec_v2_disturbed", ct, CT_V2);

      // reset around round 20
      @(negedge clk);
      din[0] = '0; key[0] = '0; start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      repeat (19) @(negedge clk);
      rst[0] = 1'b1;
      @(negedge clk);
      rst[0] = 1'b0;
      chk_b("abort_busy", 0, busy[0], 1'b0);
      chk_b("abort_valid", 0, valid[0], 1'b0);
      chk_v("abort_data", dout[0], '0);
      repeat (45) @(negedge clk);
      chk_b("abort_no_valid", 0, valid[0], 1'b0);
      run_block(0, '0, '0, 2, 1'b0, ct);
      chk_v("vec_zero_after_rst", ct, CT_ZERO);

      // back-to-back: ack and start together, start accepted only once idle
      pa = rnd128(); ka = rnd128(); pb = rnd128(); kb = rnd128();
      @(negedge clk);
      din[0] = pa; key[0] = ka; start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      wait_valid(0, lat);
      chk_v("b2b_first", dout[0], gift_enc(pa, ka, 40));
      ack[0] = 1'b1; start[0] = 1'b1; din[0] = pb; key[0] = kb;
      @(negedge clk);
      ack[0] = 1'b0;
      chk_b("b2b_idle_gap", 0, busy[0], 1'b0);
      @(negedge clk);
      start[0] = 1'b0;
      wait_valid(0, lat);
      chk_v("b2b_second", dout[0], gift_enc(pb, kb, 40));
      ack[0] = 1'b1;
      @(negedge clk);
      ack[0] = 1'b0;

      for (int n = 0; n < 4; n++) begin
         pa = rnd128(); ka = rnd128();
         run_block(0, pa, ka, int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), ct);
         chk_v("rand40", ct, gift_enc(pa, ka, 40));
      end

      // single-round engine: reset beats start, then random blocks
      @(negedge clk);
      rst[1] = 1'b1; start[1] = 1'b1; din[1] = rnd128();
      @(negedge clk);
      rst[1] = 1'b0; start[1] = 1'b0;
      chk_b("rst_wins", 1, busy[1], 1'b0);
      run_block(1, '0, '0, 1, 1'b0, ct);
      chk_v("one_round_zero", ct, CT_ONE0);
      for (int n = 0; n < 20; n++) begin
         pa = rnd128(); ka = rnd128();
         run_block(1, pa, ka, int'($urandom_range(0, 2)), 1'b0, ct);
         chk_v("rand1", ct, gift_enc(pa, ka, 1));
      end

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
